// File: rtl/mips_cache_mem_arbiter_if.sv
// Bundle of cache-side channel signals and the shared Avalon-MM master port.
//   master : arbiter view (drives grant/rvalid/rdata/beat/done, mem_*, busy)
//   slave  : requestor/memory view (drives ch_* requests, waitrequest, readdata)
// Channel vectors are flattened; channel i occupies slice i.
interface mips_cache_mem_arbiter_if #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic [NUM_CH-1:0]      ch_req;
    logic [NUM_CH-1:0]      ch_write;
    logic [32*NUM_CH-1:0]   ch_addr;
    logic [32*NUM_CH-1:0]   ch_writedata;
    logic [4*NUM_CH-1:0]    ch_byteenable;
    logic [NUM_CH-1:0]      ch_grant;
    logic [NUM_CH-1:0]      ch_rvalid;
    logic [31:0]            ch_rdata;
    logic [BEAT_W-1:0]      ch_beat;
    logic [NUM_CH-1:0]      ch_done;
    logic [31:0]            mem_address;
    logic                   mem_read;
    logic                   mem_write;
    logic [31:0]            mem_writedata;
    logic [3:0]             mem_byteenable;
    logic                   waitrequest;
    logic [31:0]            mem_readdata;
    logic                   busy;

    modport master (
        input  ch_req, ch_write, ch_addr, ch_writedata, ch_byteenable,
        input  waitrequest, mem_readdata,
        output ch_grant, ch_rvalid, ch_rdata, ch_beat, ch_done,
        output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        output busy
    );

    modport slave (
        output ch_req, ch_write, ch_addr, ch_writedata, ch_byteenable,
        output waitrequest, mem_readdata,
        input  ch_grant, ch_rvalid, ch_rdata, ch_beat, ch_done,
        input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        input  busy
    );
endinterface

// File: rtl/mips_cache_mem_arbiter.sv
// Shares one Avalon-MM master among NUM_CH cache-side requestors.
// Reads are LINE_WORDS-beat line fills from the line-aligned base; writes are
// single words. PRIO_MODE 0 = round-robin, 1 = fixed priority (channel 0 first).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : mips_cache_mem_arbiter_if.master (channel requests/responses + Avalon)
module mips_cache_mem_arbiter #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned PRIO_MODE  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    mips_cache_mem_arbiter_if.master bus
);
    localparam int unsigned BEAT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned PTR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned LAST_BEAT = LINE_WORDS - 1;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    logic                win_valid;
    logic [PTR_W-1:0]    win_idx;
    logic [NUM_CH-1:0]   owner_oh;
    logic                last_beat;

    // State and transaction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            beat_q   <= beat_d;
        end
    end

    // Winner search: cyclic from rr_ptr, or linear from 0 in fixed-priority mode
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            cand     = (PRIO_MODE != 0) ? k : (int'(rr_ptr_q) + k) % int'(NUM_CH);
            cand_idx = PTR_W'(cand);
            if (!win_valid && bus.ch_req[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign owner_oh  = NUM_CH'(1'b1) << owner_q;
    assign last_beat = (beat_q == BEAT_W'(LAST_BEAT));

    // Next-state logic and Avalon/channel output decode
    always_comb begin
        state_d            = state_q;
        owner_d            = owner_q;
        rr_ptr_d           = rr_ptr_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        be_d               = be_q;
        beat_d             = beat_q;
        bus.ch_grant       = '0;
        bus.ch_rvalid      = '0;
        bus.ch_done        = '0;
        bus.mem_address    = '0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_byteenable = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    owner_d  = win_idx;
                    addr_d   = 32'(bus.ch_addr >> {win_idx, 5'd0});
                    wdata_d  = 32'(bus.ch_writedata >> {win_idx, 5'd0});
                    be_d     = 4'(bus.ch_byteenable >> {win_idx, 2'd0});
                    beat_d   = '0;
                    rr_ptr_d = (win_idx == PTR_W'(NUM_CH - 1)) ? '0 : win_idx + PTR_W'(1);
                    state_d  = bus.ch_write[win_idx] ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                bus.ch_grant       = owner_oh;
                bus.mem_read       = 1'b1;
                bus.mem_byteenable = 4'hF;
                bus.mem_address    = (addr_q & LINE_MASK) | (32'(beat_q) << 2);
                if (!bus.waitrequest) begin
                    bus.ch_rvalid = owner_oh;
                    if (last_beat) begin
                        bus.ch_done = owner_oh;
                        beat_d      = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                bus.ch_grant       = owner_oh;
                bus.mem_write      = 1'b1;
                bus.mem_byteenable = be_q;
                bus.mem_address    = {addr_q[31:2], 2'b00};
                if (!bus.waitrequest) begin
                    bus.ch_done = owner_oh;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_writedata = wdata_q;
    assign bus.ch_rdata      = bus.mem_readdata;
    assign bus.ch_beat       = beat_q;
    assign bus.busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mips_cache_mem_arbiter.sv
// Bench for mips_cache_mem_arbiter: a round-robin and a fixed-priority instance
// share identical stimulus; each is checked every cycle against a
// transaction-level model, plus directed checks of the documented scenarios.
module tb_mips_cache_mem_arbiter;
    localparam int NC = 3;
    localparam int LW = 4;

    typedef struct packed {
        logic [2:0]  grant;
        logic [2:0]  rvalid;
        logic [2:0]  done;
        logic [1:0]  beat;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        busy;
    } obs_t;

    logic        clk;
    logic        rst;
    logic [2:0]  req, wr;
    logic [95:0] addr, wdat;
    logic [11:0] be;
    logic        waitreq;
    logic [31:0] rdata;

    int n_run, n_fail;

    mips_cache_mem_arbiter_if #(.NUM_CH(NC), .LINE_WORDS(LW)) if_rr ();
    mips_cache_mem_arbiter_if #(.NUM_CH(NC), .LINE_WORDS(LW)) if_fp ();

    mips_cache_mem_arbiter #(.NUM_CH(NC), .LINE_WORDS(LW), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .bus(if_rr));
    mips_cache_mem_arbiter #(.NUM_CH(NC), .LINE_WORDS(LW), .PRIO_MODE(1)) u_fp (
        .clk(clk), .rst(rst), .bus(if_fp));

    assign if_rr.ch_req = req;         assign if_fp.ch_req = req;
    assign if_rr.ch_write = wr;        assign if_fp.ch_write = wr;
    assign if_rr.ch_addr = addr;       assign if_fp.ch_addr = addr;
    assign if_rr.ch_writedata = wdat;  assign if_fp.ch_writedata = wdat;
    assign if_rr.ch_byteenable = be;   assign if_fp.ch_byteenable = be;
    assign if_rr.waitrequest = waitreq; assign if_fp.waitrequest = waitreq;
    assign if_rr.mem_readdata = rdata; assign if_fp.mem_readdata = rdata;

    obs_t act_rr, act_fp;
    always_comb begin
        act_rr.grant = if_rr.ch_grant;   act_fp.grant = if_fp.ch_grant;
        act_rr.rvalid = if_rr.ch_rvalid; act_fp.rvalid = if_fp.ch_rvalid;
        act_rr.done = if_rr.ch_done;     act_fp.done = if_fp.ch_done;
        act_rr.beat = if_rr.ch_beat;     act_fp.beat = if_fp.ch_beat;
        act_rr.rd = if_rr.mem_read;      act_fp.rd = if_fp.mem_read;
        act_rr.wr = if_rr.mem_write;     act_fp.wr = if_fp.mem_write;
        act_rr.addr = if_rr.mem_address; act_fp.addr = if_fp.mem_address;
        act_rr.be = if_rr.mem_byteenable; act_fp.be = if_fp.mem_byteenable;
        act_rr.wdata = if_rr.mem_writedata; act_fp.wdata = if_fp.mem_writedata;
        act_rr.rdata = if_rr.ch_rdata;   act_fp.rdata = if_fp.ch_rdata;
        act_rr.busy = if_rr.busy;        act_fp.busy = if_fp.busy;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: one in-flight transfer record per arbiter (0 = rr, 1 = fp)
    bit          m_act [2];
    int          m_own [2];
    bit          m_wr  [2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wd  [2];
    logic [3:0]  m_be  [2];
    int          m_beat[2];
    int          m_ptr [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int m);
        int g;
        if (rst) begin
            m_act[m] = 0; m_own[m] = 0; m_wr[m] = 0; m_addr[m] = '0;
            m_wd[m] = '0; m_be[m] = '0; m_beat[m] = 0; m_ptr[m] = 0;
        end else if (m_act[m]) begin
            if (!waitreq) begin
                if (m_wr[m] || m_beat[m] == LW - 1) begin
                    m_act[m] = 0;
                    m_beat[m] = 0;
                end else begin
                    m_beat[m] = m_beat[m] + 1;
                end
            end
        end else if (req != 3'b000) begin
            g = -1;
            for (int k = 0; k < NC; k++) begin
                int c;
                c = (m == 1) ? k : (m_ptr[m] + k) % NC;
                if (g < 0 && req[c]) g = c;
            end
            m_act[m]  = 1;
            m_own[m]  = g;
            m_wr[m]   = wr[g];
            m_addr[m] = addr[g*32 +: 32];
            m_wd[m]   = wdat[g*32 +: 32];
            m_be[m]   = be[g*4 +: 4];
            m_beat[m] = 0;
            m_ptr[m]  = (g + 1) % NC;
        end
    endtask

    task automatic model_check(input int m);
        obs_t  a, e;
        string nm;
        logic [2:0] oh;
        a  = (m == 0) ? act_rr : act_fp;
        nm = (m == 0) ? "rr" : "fp";
        oh = m_act[m] ? (3'b001 << m_own[m]) : 3'b000;
        e.busy   = m_act[m];
        e.grant  = oh;
        e.rd     = m_act[m] && !m_wr[m];
        e.wr     = m_act[m] && m_wr[m];
        e.rvalid = (e.rd && !waitreq) ? oh : 3'b000;
        e.done   = (m_act[m] && !waitreq && (m_wr[m] || m_beat[m] == LW - 1)) ? oh : 3'b000;
        e.beat   = 2'(m_beat[m]);
        e.be     = e.rd ? 4'hF : (e.wr ? m_be[m] : 4'h0);
        e.addr   = m_wr[m] ? (m_addr[m] / 4) * 4
                           : 32'((m_addr[m] / (LW * 4)) * (LW * 4) + 32'(m_beat[m] * 4));
        e.wdata  = m_wd[m];
        e.rdata  = rdata;
        chk({nm, ".busy"},   32'(a.busy),   32'(e.busy));
        chk({nm, ".grant"},  32'(a.grant),  32'(e.grant));
        chk({nm, ".rvalid"}, 32'(a.rvalid), 32'(e.rvalid));
        chk({nm, ".done"},   32'(a.done),   32'(e.done));
        chk({nm, ".beat"},   32'(a.beat),   32'(e.beat));
        chk({nm, ".read"},   32'(a.rd),     32'(e.rd));
        chk({nm, ".write"},  32'(a.wr),     32'(e.wr));
        chk({nm, ".be"},     32'(a.be),     32'(e.be));
        chk({nm, ".wdata"},  a.wdata,       e.wdata);
        chk({nm, ".rdata"},  a.rdata,       e.rdata);
        if (e.busy) chk({nm, ".addr"}, a.addr, e.addr);
    endtask

    // Observe at the falling edge with this cycle's inputs applied
    task automatic eval();
        @(negedge clk);
        model_check(0);
        model_check(1);
    endtask

    // Clock edge: model absorbs the sampled inputs, new read data follows
    task automatic adv();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        rdata = $urandom;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        adv();
        rst = 1'b0;
    endtask

    initial begin
        bit         prev_rr, prev_fp;
        logic [2:0] req_prev, low;
        int         rr_cnt;
        n_run = 0; n_fail = 0;
        rst = 1'b1; req = '0; wr = '0; addr = '0; wdat = '0; be = '0;
        waitreq = 1'b0; rdata = 32'h0;
        adv();
        adv();
        rst = 1'b0;

        // Reset state
        eval();
        chk("reset.busy", 32'(act_rr.busy), 32'd0);
        chk("reset.grant", 32'(act_rr.grant), 32'd0);
        chk("reset.read", 32'(act_rr.rd), 32'd0);
        adv();

        // Single-word write from channel 1
        req = 3'b010; wr = 3'b010;
        addr[63:32] = 32'h0000_1003; wdat[63:32] = 32'hDEAD_BEEF; be[7:4] = 4'b0011;
        eval(); chk("wr.idle_first", 32'(act_rr.busy), 32'd0); adv();
        eval();
        chk("wr.mem_write", 32'(act_rr.wr), 32'd1);
        chk("wr.addr", act_rr.addr, 32'h0000_1000);
        chk("wr.done", 32'(act_rr.done), 32'b010);
        chk("wr.data", act_rr.wdata, 32'hDEAD_BEEF);
        chk("wr.be", 32'(act_rr.be), 32'b0011);
        adv();
        req = 3'b000;
        eval(); chk("wr.back_idle", 32'(act_rr.busy), 32'd0); adv();

        // Line fill from channel 0 with one wait state
        req = 3'b001; wr = 3'b000; addr[31:0] = 32'h0000_0204;
        eval(); adv();
        waitreq = 1'b1;
        eval();
        chk("fill.wait_addr", act_rr.addr, 32'h0000_0200);
        chk("fill.wait_rvalid", 32'(act_rr.rvalid), 32'd0);
        adv();
        waitreq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("fill.addr", act_rr.addr, 32'h0000_0200 + 32'(i * 4));
            chk("fill.rvalid", 32'(act_rr.rvalid), 32'b001);
            chk("fill.beat", 32'(act_rr.beat), 32'(i));
            chk("fill.done", 32'(act_rr.done), (i == 3) ? 32'b001 : 32'd0);
            adv();
        end
        req = 3'b000;
        eval(); chk("fill.back_idle", 32'(act_rr.busy), 32'd0); adv();

        // Round-robin rotation and fixed priority with all channels requesting
        reset_pulse();
        req = 3'b111; wr = 3'b000;
        addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        prev_rr = 0; prev_fp = 0; rr_cnt = 0; req_prev = 3'b000;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc == 40) req = 3'b110;
            if (cyc == 60) req = 3'b100;
            eval();
            if (act_rr.busy && !prev_rr && req_prev == 3'b111) begin
                chk("rr.order", 32'(act_rr.grant), 32'(3'b001 << (rr_cnt % 3)));
                rr_cnt++;
            end
            if (act_fp.busy && !prev_fp) begin
                low = req_prev & (~req_prev + 3'b001);
                chk("fp.grant", 32'(act_fp.grant), 32'(low));
            end
            prev_rr = act_rr.busy; prev_fp = act_fp.busy;
            req_prev = req;
            adv();
        end
        chk("rr.rotations_seen", 32'(rr_cnt >= 4), 32'd1);
        req = 3'b000;

        // Reset during beat 2 of a fill
        reset_pulse();
        req = 3'b001;
        eval(); adv();
        eval(); adv();
        eval(); adv();
        eval(); chk("rstmid.beat", 32'(act_rr.beat), 32'd2);
        rst = 1'b1;
        adv();
        rst = 1'b0; req = 3'b111;
        eval();
        chk("rstmid.read", 32'(act_rr.rd), 32'd0);
        chk("rstmid.busy", 32'(act_rr.busy), 32'd0);
        chk("rstmid.grant", 32'(act_rr.grant), 32'd0);
        adv();
        eval();
        chk("rstmid.first_grant_rr", 32'(act_rr.grant), 32'b001);
        chk("rstmid.first_grant_fp", 32'(act_fp.grant), 32'b001);
        adv();
        req = 3'b000;

        // Channel 2 drops its request right after the grant
        reset_pulse();
        req = 3'b100; addr[95:64] = 32'h0000_3004;
        eval(); adv();
        req = 3'b000;
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("drop.rvalid", 32'(act_rr.rvalid), 32'b100);
            chk("drop.done", 32'(act_rr.done), (i == 3) ? 32'b100 : 32'd0);
            adv();
        end
        eval(); chk("drop.idle", 32'(act_rr.busy), 32'd0); adv();

        // Randomised traffic with wait states and occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            wr = 3'($urandom);
            addr = {$urandom, $urandom, $urandom};
            wdat = {$urandom, $urandom, $urandom};
            be = 12'($urandom);
            waitreq = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 149) == 0);
            eval();
            adv();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
